// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches, buffers up to two
// {pc,instr} pairs ahead of the IF/ID register and handles redirect flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [63:0] if_id_data,
  output logic        if_id_ce,
  output logic [1:0]  buf_level
);

  localparam int unsigned DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    FULL    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        disc_addr_q, disc_addr_d;
  logic [1:0][31:0]   fifo_pc_q, fifo_pc_d;
  logic [1:0][31:0]   fifo_instr_q, fifo_instr_d;
  logic               head_q, head_d;
  logic [1:0]         count_q, count_d;

  logic               req_c;
  logic               nonempty_c;
  logic               pop_c;
  logic               push_c;
  logic               tail_c;
  logic [1:0]         unused_rpc_lo;

  assign unused_rpc_lo = redirect_pc[1:0];

  // Request/output decode; reset masks everything the pipeline can observe.
  always_comb begin
    req_c      = !rst && ((state_q == FETCH && count_q < 2'(DEPTH)) || state_q == DISCARD);
    nonempty_c = (count_q != 2'd0);
    if_id_ce   = !rst && (!stall || redirect);
    pop_c      = if_id_ce && nonempty_c && !redirect;
    push_c     = (state_q == FETCH) && req_c && imem_ack && !redirect;
    tail_c     = head_q ^ count_q[0];
    imem_req   = req_c;
    imem_addr  = (state_q == DISCARD) ? disc_addr_q : pc_q;
    buf_level  = count_q;
    if (!rst && nonempty_c && !redirect)
      if_id_data = {fifo_pc_q[head_q], fifo_instr_q[head_q]};
    else
      if_id_data = {32'h0, NOP_INSTR};
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    disc_addr_d  = disc_addr_q;
    head_d       = head_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;

    if (redirect) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      // An unanswered request must still be consumed before refetching.
      if (req_c && !imem_ack) begin
        state_d = DISCARD;
        if (state_q != DISCARD) disc_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end else begin
      head_d = head_q ^ pop_c;
      case (state_q)
        FETCH: begin
          if (push_c) begin
            fifo_pc_d[tail_c]    = pc_q;
            fifo_instr_d[tail_c] = imem_rdata;
            pc_d                 = pc_q + 32'd4;
          end
          count_d = count_q + 2'(push_c) - 2'(pop_c);
          if (count_d == 2'(DEPTH)) state_d = FULL;
        end
        FULL: begin
          count_d = count_q - 2'(pop_c);
          if (pop_c) state_d = FETCH;
        end
        DISCARD: begin
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      disc_addr_q  <= RESET_PC;
      fifo_pc_q    <= '0;
      fifo_instr_q <= '0;
      head_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      disc_addr_q  <= disc_addr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      head_q       <= head_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based fetch model with a
// variable-latency instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [63:0] if_id_data;
  logic        if_id_ce;
  logic [1:0]  buf_level;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_data(if_id_data), .if_id_ce(if_id_ce), .buf_level(buf_level)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: buffered entries, next fetch pc, and an optional
  // abandoned request that still has to be answered.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic [31:0] m_daddr;
  bit          m_disc;

  int min_lat = 0;
  int max_lat = 0;
  int lat_tgt = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc     = RESET_PC;
    m_daddr  = RESET_PC;
    m_disc   = 1'b0;
    wait_cnt = 0;
    lat_tgt  = $urandom_range(max_lat, min_lat);
  endtask

  task automatic step(input bit s, input bit r, input logic [31:0] rpc, input bit rs);
    bit          e_req, e_ce, ack;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    rst         = rs;
    if (rs) model_reset();
    e_req  = !rs && (m_disc || q.size() < 2);
    e_addr = m_disc ? m_daddr : m_pc;
    e_ce   = !rs && (!s || r);
    e_data = (!rs && q.size() > 0 && !r) ? q[0] : {32'h0, NOP_INSTR};
    if (e_req) begin
      ack        = (wait_cnt >= lat_tgt);
      imem_ack   = ack;
      imem_rdata = ack ? mem_word(e_addr) : $urandom;
    end else begin
      ack        = 1'b0;
      imem_ack   = 1'($urandom_range(1, 0));
      imem_rdata = $urandom;
    end
    #1;
    check_eq("imem_req", 64'(imem_req), 64'(e_req));
    if (e_req) check_eq("imem_addr", 64'(imem_addr), 64'(e_addr));
    check_eq("if_id_ce", 64'(if_id_ce), 64'(e_ce));
    check_eq("if_id_data", if_id_data, e_data);
    check_eq("buf_level", 64'(buf_level), 64'(q.size()));
    @(posedge clk);
    if (!rs) begin
      if (r) begin
        q.delete();
        if (e_req && !ack) begin
          if (!m_disc) m_daddr = m_pc;
          m_disc = 1'b1;
        end else begin
          m_disc = 1'b0;
        end
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (e_ce && q.size() > 0) void'(q.pop_front());
        if (e_req && ack) begin
          if (m_disc) m_disc = 1'b0;
          else begin
            q.push_back({m_pc, imem_rdata});
            m_pc = m_pc + 32'd4;
          end
        end
      end
      if (!e_req || ack) begin
        wait_cnt = 0;
        lat_tgt  = $urandom_range(max_lat, min_lat);
      end else begin
        wait_cnt++;
      end
    end
    #1;
  endtask

  task automatic set_lat(input int lo, input int hi);
    min_lat  = lo;
    max_lat  = hi;
    wait_cnt = 0;
    lat_tgt  = $urandom_range(hi, lo);
  endtask

  initial begin
    logic [31:0] rpc;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0;
    model_reset();

    // Reset state, then same-cycle ack streaming.
    set_lat(0, 0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Three-cycle memory latency.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    set_lat(3, 3);
    repeat (20) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Five-cycle stall with fast memory fills the buffer, then drains in order.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    set_lat(0, 0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect to 0x100 while the request to 0x20 is still pending.
    set_lat(2, 2);
    step(1'b0, 1'b1, 32'h20, 1'b0);
    step(1'b0, 1'b1, 32'h103, 1'b0);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect coinciding with ack while stalled with one buffered entry.
    step(1'b0, 1'b0, 32'h0, 1'b1);
    set_lat(0, 0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h100, 1'b0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset pulse during an outstanding request to 0x40.
    set_lat(5, 5);
    step(1'b0, 1'b1, 32'h40, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
    set_lat(0, 2);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic, including address wrap and occasional reset.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99, 0) < 3) set_lat(0, $urandom_range(4, 0));
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                        : 32'($urandom);
      step(($urandom_range(99, 0) < 30), ($urandom_range(99, 0) < 8), rpc,
           ($urandom_range(199, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
